// File: rtl/key_filter_if.sv
// Key filter bus: raw active-low keys in, debounced level and event pulses out.
// The master side (stimulus or parent logic) drives key_n; the slave side is the filter.
interface key_filter_if;
  logic [3:0] key_n;
  logic [3:0] key_level;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;
  logic       run_en;

  modport master (
    output key_n,
    input  key_level, key_press, key_release, key_long, run_en
  );

  modport slave (
    input  key_n,
    output key_level, key_press, key_release, key_long, run_en
  );
endinterface

// File: rtl/key_filter.sv
// key_filter: four independent debouncers for bouncing active-low push-buttons.
// Each key has a 2-flop synchronizer, a 4-state filter FSM and a 20-bit counter.
// Outputs: debounced level, registered one-cycle press/release pulses, and a
// run_en flag that flips on every accepted press of key 0.
// Optional feature: define KEY_LONG_PRESS_EN to build per-key 26-bit hold
// counters that pulse key_long once a key has been held LONG_VAL+1 cycles.
// Without the macro key_long is tied to zero.
module key_filter #(
  parameter logic [19:0] DEBOUNCE_VAL = 20'd999_999,
  parameter logic [25:0] LONG_VAL     = 26'd49_999_999
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  key_filter_if.slave kbus
);

  typedef enum logic [1:0] {IDLE, PRESS_FILT, DOWN, REL_FILT} state_t;

  logic [3:0]  sync_q;
  logic [3:0]  key_s;
  state_t      state_q [4];
  state_t      state_d [4];
  logic [19:0] cnt_q   [4];
  logic [19:0] cnt_d   [4];
  logic [3:0]  level_q, level_d;
  logic [3:0]  press_q, press_d;
  logic [3:0]  rel_q,   rel_d;
  logic        run_en_q;

  // Two-flop synchronizer per key; idles at 1 (released) out of reset.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 4'b1111;
      key_s  <= 4'b1111;
    end else begin
      sync_q <= kbus.key_n;
      key_s  <= sync_q;
    end
  end

  // Filter next-state logic: a press or release is accepted only after the
  // synchronized input stays stable for DEBOUNCE_VAL+1 consecutive cycles.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    for (int k = 0; k < 4; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        IDLE: begin
          if (!key_s[k]) begin
            state_d[k] = PRESS_FILT;
            cnt_d[k]   = '0;
          end
        end
        PRESS_FILT: begin
          if (key_s[k]) begin
            state_d[k] = IDLE;
          end else if (cnt_q[k] == DEBOUNCE_VAL) begin
            state_d[k] = DOWN;
            level_d[k] = 1'b1;
            press_d[k] = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 20'd1;
          end
        end
        DOWN: begin
          if (key_s[k]) begin
            state_d[k] = REL_FILT;
            cnt_d[k]   = '0;
          end
        end
        REL_FILT: begin
          if (!key_s[k]) begin
            state_d[k] = DOWN;
          end else if (cnt_q[k] == DEBOUNCE_VAL) begin
            state_d[k] = IDLE;
            level_d[k] = 1'b0;
            rel_d[k]   = 1'b1;
          end else begin
            cnt_d[k] = cnt_q[k] + 20'd1;
          end
        end
        default: state_d[k] = IDLE;
      endcase
    end
  end

  // Filter state, counters and registered outputs; run_en flips after a key-0 press pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= IDLE;
        cnt_q[k]   <= '0;
      end
      level_q  <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      run_en_q <= 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      level_q  <= level_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      run_en_q <= run_en_q ^ press_q[0];
    end
  end

`ifdef KEY_LONG_PRESS_EN
  logic [25:0] hold_q [4];
  logic [25:0] hold_d [4];
  logic [3:0]  fired_q, fired_d;
  logic [3:0]  long_q,  long_d;

  // Hold timer: restarts on every entry to DOWN, runs through DOWN and
  // REL_FILT, saturates at LONG_VAL and fires key_long once per hold.
  always_comb begin
    long_d  = '0;
    fired_d = fired_q;
    for (int k = 0; k < 4; k++) begin
      hold_d[k] = hold_q[k];
      if (state_d[k] == DOWN && state_q[k] != DOWN) begin
        hold_d[k]  = '0;
        fired_d[k] = 1'b0;
      end else if (state_d[k] == IDLE) begin
        hold_d[k]  = '0;
        fired_d[k] = 1'b0;
      end else if (state_q[k] == DOWN || state_q[k] == REL_FILT) begin
        if (hold_q[k] == LONG_VAL) begin
          if (!fired_q[k]) begin
            long_d[k]  = 1'b1;
            fired_d[k] = 1'b1;
          end
        end else begin
          hold_d[k] = hold_q[k] + 26'd1;
        end
      end
    end
  end

  // Hold counters, once-only flags and the registered long-press pulse.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) hold_q[k] <= '0;
      fired_q <= '0;
      long_q  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) hold_q[k] <= hold_d[k];
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign kbus.key_long = long_q;
`else
  assign kbus.key_long = 4'b0000;
`endif

  assign kbus.key_level   = level_q;
  assign kbus.key_press   = press_q;
  assign kbus.key_release = rel_q;
  assign kbus.run_en      = run_en_q;

endmodule

// File: tb/tb_key_filter.sv
// Testbench for key_filter with DEBOUNCE_VAL=4, LONG_VAL=20.
// Stimulus pushes expected output events (cycle, pulses, level, run_en) into a
// queue; a negedge monitor pops and compares whenever the outputs change.
module tb_key_filter;

  typedef struct packed {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lng;
    logic [3:0] level;
    logic       run;
  } ev_t;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  ev_t        exp_q[$];
  ev_t        act_ev, exp_ev;
  logic [3:0] prev_level = '0;
  logic       prev_run   = 1'b0;

  key_filter_if kb();

  key_filter #(
    .DEBOUNCE_VAL(20'd4),
    .LONG_VAL    (26'd20)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n  (rst_n),
    .kbus   (kb)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] pr, input logic [3:0] rl,
                      input logic [3:0] lg, input logic [3:0] lv, input logic rn);
    ev_t e;
    e.cyc = c; e.press = pr; e.rel = rl; e.lng = lg; e.level = lv; e.run = rn;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, expv);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  // Monitor: any pulse, level change or run_en change is an event to score.
  always @(negedge sys_clk) begin
    if (!rst_n) begin
      prev_level = '0;
      prev_run   = 1'b0;
    end else if ((kb.key_press | kb.key_release | kb.key_long) != 4'b0000 ||
                 kb.key_level != prev_level || kb.run_en != prev_run) begin
      act_ev.cyc   = cyc;
      act_ev.press = kb.key_press;
      act_ev.rel   = kb.key_release;
      act_ev.lng   = kb.key_long;
      act_ev.level = kb.key_level;
      act_ev.run   = kb.run_en;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_event: got cyc=%0d press=%b rel=%b long=%b level=%b run=%b, expected no event",
                 act_ev.cyc, act_ev.press, act_ev.rel, act_ev.lng, act_ev.level, act_ev.run);
      end else begin
        exp_ev = exp_q.pop_front();
        if (act_ev == exp_ev) n_pass++;
        else $display("FAIL event: got cyc=%0d press=%b rel=%b long=%b level=%b run=%b, expected cyc=%0d press=%b rel=%b long=%b level=%b run=%b",
                      act_ev.cyc, act_ev.press, act_ev.rel, act_ev.lng, act_ev.level, act_ev.run,
                      exp_ev.cyc, exp_ev.press, exp_ev.rel, exp_ev.lng, exp_ev.level, exp_ev.run);
      end
      prev_level = kb.key_level;
      prev_run   = kb.run_en;
    end
  end

  initial begin
    int c;
    kb.key_n = 4'b1111;
    rst_n    = 1'b0;

    // Reset state
    wait_cyc(3);
    #1 chk("reset_state", {kb.key_level, kb.key_press, kb.key_release, kb.key_long, kb.run_en}, 17'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    wait_cyc(3);

    // Key 0 press: press pulse + level at +8, run_en toggles at +9; then release.
    c = cyc; kb.key_n = 4'b1110;
    push(c + 8, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    push(c + 9, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    wait_cyc(12);
    c = cyc; kb.key_n = 4'b1111;
    push(c + 8, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1);
    wait_cyc(12);

    // Key 1 glitch of 3 cycles: no event at all.
    kb.key_n = 4'b1101;
    wait_cyc(3);
    kb.key_n = 4'b1111;
    wait_cyc(12);
    chk("glitch_level", {13'd0, kb.key_level}, 17'd0);

    // Key 2 held, 2-cycle release bounce while DOWN, then a stable release.
    c = cyc; kb.key_n = 4'b1011;
    push(c + 8, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    wait_cyc(12);
    kb.key_n = 4'b1111;
    wait_cyc(2);
    kb.key_n = 4'b1011;
    wait_cyc(12);
    chk("bounce_level", {13'd0, kb.key_level}, {13'd0, 4'b0100});
    c = cyc; kb.key_n = 4'b1111;
    push(c + 8, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1);
    wait_cyc(12);

    // All keys together: one 4'b1111 press, run_en toggles once.
    c = cyc; kb.key_n = 4'b0000;
    push(c + 8, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1);
    push(c + 9, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b0);
    wait_cyc(10);
    c = cyc; kb.key_n = 4'b1111;
    push(c + 8, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(12);

    // Key 3 held 40 cycles past its press: long pulse 21 cycles after press.
    c = cyc; kb.key_n = 4'b0111;
    push(c + 8, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 1'b0);
`ifdef KEY_LONG_PRESS_EN
    push(c + 29, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 1'b0);
`endif
    wait_cyc(48);
    c = cyc; kb.key_n = 4'b1111;
    push(c + 8, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    wait_cyc(12);

    // Keys 0+1 pressed, key 0 released, key 0 re-pressed, reset mid-filter.
    c = cyc; kb.key_n = 4'b1100;
    push(c + 8, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    push(c + 9, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1);
    wait_cyc(10);
    c = cyc; kb.key_n = 4'b1101;
    push(c + 8, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 1'b1);
    wait_cyc(10);
    kb.key_n = 4'b1100;
    wait_cyc(4);
    #3 rst_n = 1'b0;
    #1 chk("reset_async", {kb.key_level, kb.key_press, kb.key_release, kb.key_long, kb.run_en}, 17'd0);
    wait_cyc(2);
    c = cyc; rst_n = 1'b1;
    push(c + 8, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 1'b0);
    push(c + 9, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 1'b1);
    wait_cyc(12);
    c = cyc; kb.key_n = 4'b1111;
    push(c + 8, 4'b0000, 4'b0011, 4'b0000, 4'b0000, 1'b1);
    wait_cyc(15);

    // Any expected event never seen is a failure.
    while (exp_q.size() != 0) begin
      exp_ev = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_event: got nothing, expected cyc=%0d press=%b rel=%b long=%b level=%b run=%b",
               exp_ev.cyc, exp_ev.press, exp_ev.rel, exp_ev.lng, exp_ev.level, exp_ev.run);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter DEBOUNCE_VAL, 20'd999_999, last debounce counter value; filter time is DEBOUNCE_VAL+1 cycles, 20 ms at 50 MHz.
REQ-002 Parameter LONG_VAL, 26'd49_999_999, last long-press counter value; 1 s at 50 MHz.
REQ-003 sys_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 key_n  input  4  raw push-buttons; asynchronous, bouncing, active-low (0 = pressed).
REQ-006 key_level  output  4  debounced key state; 1 = pressed.
REQ-007 key_press  output  4  one-cycle pulse per accepted press.
REQ-008 key_release  output  4  one-cycle pulse per accepted release.
REQ-009 key_long  output  4  one-cycle pulse when a key has been held LONG_VAL+1 cycles in DOWN.
REQ-010 run_en  output  1  toggle flag that drives the flow-LED en input.

Function
REQ-011 Each key_n bit SHALL pass through its own 2-flop synchronizer (key_s); keys are fully independent, with one FSM and one 20-bit counter per key.
REQ-012 FSM states SHALL be IDLE, PRESS_FILT, DOWN and REL_FILT.
REQ-013 IDLE: if key_s==0, go to PRESS_FILT and clear cnt.
REQ-014 PRESS_FILT: if key_s==1, return to IDLE (bounce) with no pulse; else if cnt==DEBOUNCE_VAL, go to DOWN, set key_level=1 and pulse key_press; else increment cnt.
REQ-015 DOWN: if key_s==1, go to REL_FILT and clear cnt; key_level stays 1.
REQ-016 REL_FILT: if key_s==0, return to DOWN with no pulse; else if cnt==DEBOUNCE_VAL, go to IDLE, set key_level=0 and pulse key_release; else increment cnt.
REQ-017 Latency: with key_n held low from the first edge e0 that samples it, key_press SHALL be high for exactly the one cycle after edge e0+DEBOUNCE_VAL+3; key_level SHALL rise on that same edge; release timing is symmetric.
REQ-018 Every pulse output SHALL be registered, one cycle wide, and issued at most once per press or release.
REQ-019 cnt SHALL never exceed DEBOUNCE_VAL and SHALL never wrap.
REQ-020 run_en SHALL invert on the edge after a cycle in which key_press[0]==1; other keys do not affect it.
REQ-021 Simultaneous presses on several keys SHALL each produce their own key_press bit in the same cycle when their timing matches.

Reset
REQ-022 When rst_n==0, the block SHALL immediately and asynchronously set: synchronizer flops to 1, all FSMs to IDLE, all counters to 0, and key_level, key_press, key_release, key_long and run_en to 0.
REQ-023 Reset asserted mid-filter or mid-hold SHALL discard the pending event; after release, a key still held SHALL be re-filtered from IDLE and produce a fresh key_press.

Configuration
REQ-024 Macro KEY_LONG_PRESS_EN defined: each key SHALL have a 26-bit hold counter that clears on entry to DOWN and increments while in DOWN and REL_FILT, saturating at LONG_VAL; key_long SHALL pulse once when it reaches LONG_VAL; the counter clears on entry to IDLE.
REQ-025 Macro KEY_LONG_PRESS_EN undefined: the hold counters SHALL not be built and key_long SHALL be constant 4'b0000; the port list is unchanged.

Verification (DEBOUNCE_VAL=4, LONG_VAL=20)
REQ-026 key_n[0] driven low at e0 and held -> key_press[0] high only in the cycle after e7; key_level[0]=1 from e7; run_en toggles 0->1 at e8.
REQ-027 key_n[1] glitches low for 3 cycles, then high -> no key_press[1], key_level[1] stays 0.
REQ-028 Key 2 held, then key_n[2] high for 2 cycles during DOWN -> FSM returns to DOWN, no key_release[2]; a later stable release gives exactly one key_release[2].
REQ-029 key_n[3:0] all low together -> key_press=4'b1111 for one cycle; run_en toggles once.
REQ-030 With KEY_LONG_PRESS_EN, key 3 held 40 cycles past key_press -> exactly one key_long[3] pulse, 21 cycles after key_press[3]; without the macro, key_long stays 0.
REQ-031 rst_n pulsed low mid-PRESS_FILT with key 0 held -> all outputs 0 at once; after release, key_press[0] again fires 7 edges after the first post-reset sample.
